io_write_arbiter: RTL

Round-robin arbiter that shares the single IO write bus (addr / datain / write_io_enable) of the output-port register bank between four requesters: the CPU store path plus up to three autonomous masters. It grants one requester at a time, presents its address and data as a registered one-cycle write, and acknowledges the winner. It also filters writes whose word address falls outside the output-port window.

---
 rtl/io_write_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/io_write_arbiter.sv
// io_write_arbiter: round-robin arbiter for the output-port IO write bus with a port-window address filter.
// Define IO_ARB_CPU_PRIO_EN to give requester 0 (CPU) fixed priority over a 1..3 round-robin.
module io_write_arbiter #(
  parameter logic [5:0] PORT_LO = 6'h20,
  parameter logic [5:0] PORT_HI = 6'h25
) (
  input  logic         io_clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [127:0] req_addr,
  input  logic [127:0] req_data,
  output logic [31:0]  addr,
  output logic [31:0]  datain,
  output logic         write_io_enable,
  output logic [3:0]   ack,
  output logic [1:0]   grant_id,
  output logic         busy,
  output logic         addr_err
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [1:0] gid_q, gid_d, rr_q, rr_d, win, idx;
  logic err_q, err_d, found, in_win;
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    found = 1'b0;
`ifdef IO_ARB_CPU_PRIO_EN
    found = req[0];
`endif
    for (int i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign in_win = (addr_q[7:2] >= PORT_LO) && (addr_q[7:2] <= PORT_HI);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    gid_d = gid_q;
    rr_d = rr_q;
    err_d = err_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = WRITE;
        addr_d = req_addr[{win, 5'd0} +: 32];
        data_d = req_data[{win, 5'd0} +: 32];
        gid_d = win;
`ifdef IO_ARB_CPU_PRIO_EN
        rr_d = (win == 2'd0) ? rr_q : (win == 2'd3) ? 2'd1 : win + 2'd1;
`else
        rr_d = win + 2'd1;
`endif
      end
    end else begin
      state_d = IDLE;
      err_d = err_q | ~in_win;
    end
  end
  always_ff @(posedge io_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= 32'd0;
      data_q <= 32'd0;
      gid_q <= 2'd0;
      rr_q <= 2'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      gid_q <= gid_d;
      rr_q <= rr_d;
      err_q <= err_d;
    end
  end
  // strobes come straight from the state register so reset kills them at once
  assign busy = (state_q == WRITE);
  assign ack = busy ? (4'b0001 << gid_q) : 4'b0000;
  assign write_io_enable = busy & in_win;
  assign addr = addr_q;
  assign datain = data_q;
  assign grant_id = gid_q;
  assign addr_err = err_q;
endmodule
